// File: rtl/csr_bridge_pkg.sv
// Shared definitions for the CSR access bridge.
// Holds the bridge FSM state type, the default readdata returned for
// timed-out reads, and the widths of the stall and timeout counters.
package csr_bridge_pkg;

   // Bridge handshake states: wait for host, drive channel, complete to host
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } bridge_state_t;

   localparam logic [31:0] DEFAULT_TIMEOUT_READDATA = 32'hDEAD_C0DE;

   // Stall counter must hold TIMEOUT_CYCLES-1 for the largest legal limit
   localparam int STALL_CNT_W = 16;

   // Width of the saturating count of timed-out accesses
   localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/csr_timeout_counter.sv
// Stall counter for one downstream access.
// Counts cycles in which the channel holds off the bridge and flags the
// cycle in which the stall reaches the configured limit.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : restart counting from zero (start of a new access)
//   enable     : this cycle is a stalled issue cycle
//   limit      : counter value at which a stalled cycle is the last allowed
//   expired    : high in the stalled cycle where the count equals limit
module csr_timeout_counter
   import csr_bridge_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   enable,
   input  logic [STALL_CNT_W-1:0] limit,
   output logic                   expired
);

   logic [STALL_CNT_W-1:0] count;

   // Count stalled cycles; a fresh access always starts from zero.
   // The bridge leaves the issue state on expiry, so the counter never
   // needs to stop itself at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + STALL_CNT_W'(1);
      end
   end

   // Expiry is combinational so the bridge can terminate in the same
   // cycle the limit is reached
   assign expired = enable && (count == limit);

endmodule

// File: rtl/csr_access_bridge.sv
// CSR access bridge between a host master port and the channel decoder
// slave port. Each host access is captured, forwarded once to the channel,
// and completed back to the host. A channel that stalls too long has its
// access forcibly terminated and is recorded as a timeout.
// Ports:
//   csr_clk_clk, csr_clk_reset_reset_n : clock, async active-low reset
//   host_*        : host side (address, read/write strobes, data, waitrequest)
//   chan_*        : channel side (address, strobes, data, waitrequest)
//   timeout_error : sticky timeout flag, cleared by timeout_clear
//   timeout_count : saturating number of timed-out accesses
module csr_access_bridge
   import csr_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES   = 1024,
   parameter logic [31:0] TIMEOUT_READDATA = DEFAULT_TIMEOUT_READDATA
) (
   input  logic                 csr_clk_clk,
   input  logic                 csr_clk_reset_reset_n,
   input  logic [15:0]          host_address,
   input  logic                 host_read,
   input  logic                 host_write,
   input  logic [31:0]          host_writedata,
   output logic [31:0]          host_readdata,
   output logic                 host_waitrequest,
   output logic [15:0]          chan_address,
   output logic                 chan_read,
   output logic                 chan_write,
   output logic [31:0]          chan_writedata,
   input  logic [31:0]          chan_readdata,
   input  logic                 chan_waitrequest,
   output logic                 timeout_error,
   input  logic                 timeout_clear,
   output logic [ERR_CNT_W-1:0] timeout_count
);

   // Last stalled-cycle count allowed before the access is terminated
   localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES - 1);

   bridge_state_t state;
   logic          stall_clear;
   logic          stall_enable;
   logic          stall_expired;

   // A new access restarts the stall count; only stalled issue cycles count
   assign stall_clear  = (state == ST_IDLE) && (host_read || host_write);
   assign stall_enable = (state == ST_ISSUE) && chan_waitrequest;

   csr_timeout_counter u_timeout_counter (
      .clk     (csr_clk_clk),
      .rst_n   (csr_clk_reset_reset_n),
      .clear   (stall_clear),
      .enable  (stall_enable),
      .limit   (STALL_LIMIT),
      .expired (stall_expired)
   );

   // Bridge FSM with all host and channel outputs registered.
   // The channel strobes double as the captured operation while issuing.
   // A simultaneous read and write request is treated as a write.
   // A clear of the error flag is written first so that a timeout in the
   // same cycle overrides it. Only reads load readdata; a write leaves
   // the host seeing the previous value, even when it times out.
   always_ff @(posedge csr_clk_clk or negedge csr_clk_reset_reset_n) begin
      if (!csr_clk_reset_reset_n) begin
         state            <= ST_IDLE;
         host_waitrequest <= 1'b1;
         host_readdata    <= '0;
         chan_address     <= '0;
         chan_writedata   <= '0;
         chan_read        <= 1'b0;
         chan_write       <= 1'b0;
         timeout_error    <= 1'b0;
         timeout_count    <= '0;
      end else begin
         if (timeout_clear) begin
            timeout_error <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               host_waitrequest <= 1'b1;
               if (host_read || host_write) begin
                  state          <= ST_ISSUE;
                  chan_address   <= host_address;
                  chan_writedata <= host_writedata;
                  chan_write     <= host_write;
                  chan_read      <= host_read && !host_write;
               end
            end
            ST_ISSUE: begin
               if (!chan_waitrequest) begin
                  if (chan_read) begin
                     host_readdata <= chan_readdata;
                  end
                  chan_read        <= 1'b0;
                  chan_write       <= 1'b0;
                  host_waitrequest <= 1'b0;
                  state            <= ST_DONE;
               end else if (stall_expired) begin
                  if (chan_read) begin
                     host_readdata <= TIMEOUT_READDATA;
                  end
                  chan_read        <= 1'b0;
                  chan_write       <= 1'b0;
                  host_waitrequest <= 1'b0;
                  timeout_error    <= 1'b1;
                  if (timeout_count != {ERR_CNT_W{1'b1}}) begin
                     timeout_count <= timeout_count + ERR_CNT_W'(1);
                  end
                  state            <= ST_DONE;
               end
            end
            ST_DONE: begin
               host_waitrequest <= 1'b1;
               state            <= ST_IDLE;
            end
            default: begin
               host_waitrequest <= 1'b1;
               chan_read        <= 1'b0;
               chan_write       <= 1'b0;
               state            <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_bridge.sv
// Testbench for csr_access_bridge with an 8-cycle timeout.
// Directed vectors from a table, hand-written reset/clear sequences, then
// randomized accesses checked against a transaction-level model.
module tb_csr_access_bridge;

   localparam int          T    = 8;
   localparam logic [31:0] DEAD = 32'hDEAD_C0DE;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] host_address = '0;
   logic        host_read = 1'b0;
   logic        host_write = 1'b0;
   logic [31:0] host_writedata = '0;
   logic [31:0] host_readdata;
   logic        host_waitrequest;
   logic [15:0] chan_address;
   logic        chan_read;
   logic        chan_write;
   logic [31:0] chan_writedata;
   logic [31:0] chan_readdata = '0;
   logic        chan_waitrequest = 1'b1;
   logic        timeout_error;
   logic        timeout_clear = 1'b0;
   logic [15:0] timeout_count;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          stall;
      logic [31:0] rdv;
      int          exp_strobes;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[6];

   int          s_cnt;
   int          l_cnt;
   logic [31:0] r_val;
   logic        ops_ok;
   logic        quiet_ok;

   // Model state for the randomized phase
   logic [31:0] m_rd;
   logic        m_err;
   logic [15:0] m_cnt;

   csr_access_bridge #(
      .TIMEOUT_CYCLES   (T),
      .TIMEOUT_READDATA (DEAD)
   ) dut (
      .csr_clk_clk           (clk),
      .csr_clk_reset_reset_n (rst_n),
      .host_address          (host_address),
      .host_read             (host_read),
      .host_write            (host_write),
      .host_writedata        (host_writedata),
      .host_readdata         (host_readdata),
      .host_waitrequest      (host_waitrequest),
      .chan_address          (chan_address),
      .chan_read             (chan_read),
      .chan_write            (chan_write),
      .chan_writedata        (chan_writedata),
      .chan_readdata         (chan_readdata),
      .chan_waitrequest      (chan_waitrequest),
      .timeout_error         (timeout_error),
      .timeout_clear         (timeout_clear),
      .timeout_count         (timeout_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one host access and act as the channel slave: hold waitrequest
   // for 'stall' issue cycles, then complete with rdv. Reports the number
   // of strobed cycles, cycles until host completion, the readdata seen at
   // completion and whether the channel-side request stayed correct.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                                input logic [31:0] wd, input int stall, input logic [31:0] rdv,
                                input int clear_at, input logic drop,
                                output int strobes, output int lat,
                                output logic [31:0] hrd, output logic ok);
      logic done;
      done    = 1'b0;
      ok      = 1'b1;
      strobes = 0;
      lat     = 0;
      hrd     = '0;
      host_read      = rd;
      host_write     = wr;
      host_address   = a;
      host_writedata = wd;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         timeout_clear    = 1'b0;
         chan_waitrequest = 1'b1;
         chan_readdata    = $urandom;
         if (chan_read || chan_write) begin
            strobes++;
            if (chan_address !== a || chan_writedata !== wd ||
                chan_write !== wr || chan_read !== (rd && !wr)) begin
               ok = 1'b0;
            end
            if (strobes > stall) begin
               chan_waitrequest = 1'b0;
               chan_readdata    = rdv;
            end
            if (strobes == clear_at) begin
               timeout_clear = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         lat++;
         if (drop && lat == 1) begin
            host_read  = 1'b0;
            host_write = 1'b0;
         end
         if (!host_waitrequest) begin
            done = 1'b1;
            hrd  = host_readdata;
         end
      end
      timeout_clear    = 1'b0;
      host_read        = 1'b0;
      host_write       = 1'b0;
      chan_waitrequest = 1'b1;
      if (!done) begin
         lat = -1;
         checkOutput("completion_bound", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   // Single-cycle pulse of the error clear
   task automatic pulseClear();
      timeout_clear = 1'b1;
      @(posedge clk);
      #1;
      timeout_clear = 1'b0;
   endtask

   // Reset with idle inputs, released away from the clock edge
   task automatic resetDut();
      host_read        = 1'b0;
      host_write       = 1'b0;
      timeout_clear    = 1'b0;
      chan_waitrequest = 1'b1;
      rst_n            = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      // Asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_waitrequest", 32'(host_waitrequest), 32'd1);
      checkOutput("rst_readdata", host_readdata, 32'd0);
      checkOutput("rst_strobes", 32'({chan_read, chan_write}), 32'd0);
      checkOutput("rst_chan_address", 32'(chan_address), 32'd0);
      checkOutput("rst_chan_writedata", chan_writedata, 32'd0);
      checkOutput("rst_error", 32'(timeout_error), 32'd0);
      checkOutput("rst_count", 32'(timeout_count), 32'd0);
      resetDut();

      // Directed vectors; later rows depend on earlier readdata/error state
      vecs[0] = '{1'b1, 1'b0, 16'h0200, 32'h0000_0000, 0,  32'h1234_5678, 1, 2, 32'h1234_5678, 1'b0, 16'd0};
      vecs[1] = '{1'b0, 1'b1, 16'h4010, 32'hA5A5_0001, 5,  32'h0BAD_0BAD, 6, 7, 32'h1234_5678, 1'b0, 16'd0};
      vecs[2] = '{1'b1, 1'b0, 16'h0104, 32'h0000_0000, 7,  32'hCAFE_F00D, 8, 9, 32'hCAFE_F00D, 1'b0, 16'd0};
      vecs[3] = '{1'b1, 1'b0, 16'h0108, 32'h0000_0000, 20, 32'h7777_7777, 8, 9, DEAD,          1'b1, 16'd1};
      vecs[4] = '{1'b1, 1'b1, 16'h0004, 32'h1111_2222, 2,  32'h3333_4444, 3, 4, DEAD,          1'b1, 16'd1};
      vecs[5] = '{1'b0, 1'b1, 16'h0008, 32'h5555_6666, 9,  32'h3333_4444, 8, 9, DEAD,          1'b1, 16'd2};
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
                       vecs[i].rdv, 0, 1'b0, s_cnt, l_cnt, r_val, ops_ok);
         checkOutput($sformatf("vec%0d_strobes", i), 32'(s_cnt), 32'(vecs[i].exp_strobes));
         checkOutput($sformatf("vec%0d_latency", i), 32'(l_cnt), 32'(vecs[i].exp_lat));
         checkOutput($sformatf("vec%0d_readdata", i), r_val, vecs[i].exp_rd);
         checkOutput($sformatf("vec%0d_error", i), 32'(timeout_error), 32'(vecs[i].exp_err));
         checkOutput($sformatf("vec%0d_count", i), 32'(timeout_count), 32'(vecs[i].exp_cnt));
         checkOutput($sformatf("vec%0d_chan_request", i), 32'(ops_ok), 32'd1);
      end

      // Lone clear, then a timeout coinciding with a clear, then a lone clear
      pulseClear();
      checkOutput("clear_error", 32'(timeout_error), 32'd0);
      checkOutput("clear_count", 32'(timeout_count), 32'd2);
      applyStimulus(1'b1, 1'b0, 16'h0010, 32'h0, 20, 32'h1, T, 1'b0, s_cnt, l_cnt, r_val, ops_ok);
      checkOutput("setwins_error", 32'(timeout_error), 32'd1);
      checkOutput("setwins_count", 32'(timeout_count), 32'd3);
      checkOutput("setwins_readdata", r_val, DEAD);
      pulseClear();
      checkOutput("clear2_error", 32'(timeout_error), 32'd0);
      checkOutput("clear2_count", 32'(timeout_count), 32'd3);

      // Reset in the middle of an issue phase
      host_read        = 1'b1;
      host_address     = 16'h0300;
      chan_waitrequest = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_issue_read", 32'(chan_read), 32'd1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_chan_read", 32'(chan_read), 32'd0);
      checkOutput("midrst_waitrequest", 32'(host_waitrequest), 32'd1);
      checkOutput("midrst_count", 32'(timeout_count), 32'd0);
      host_read = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      quiet_ok = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (!host_waitrequest || chan_read || chan_write) quiet_ok = 1'b0;
      end
      checkOutput("midrst_no_completion", 32'(quiet_ok), 32'd1);
      applyStimulus(1'b1, 1'b0, 16'h0300, 32'h0, 1, 32'h5EED_0001, 0, 1'b0, s_cnt, l_cnt, r_val, ops_ok);
      checkOutput("b2b_read_latency", 32'(l_cnt), 32'd3);
      checkOutput("b2b_read_data", r_val, 32'h5EED_0001);
      applyStimulus(1'b0, 1'b1, 16'h0304, 32'h0F0F_0F0F, 0, 32'h0, 0, 1'b0, s_cnt, l_cnt, r_val, ops_ok);
      checkOutput("b2b_write_latency", 32'(l_cnt), 32'd2);
      checkOutput("b2b_write_request", 32'(ops_ok), 32'd1);
      checkOutput("b2b_write_hold", r_val, 32'h5EED_0001);

      // Randomized accesses against a transaction-level model
      resetDut();
      m_rd  = '0;
      m_err = 1'b0;
      m_cnt = '0;
      for (int n = 0; n < 40; n++) begin
         int          op;
         int          stall;
         int          exp_s;
         logic        rd;
         logic        wr;
         logic        to;
         logic [31:0] rdv;
         logic [15:0] a;
         logic [31:0] wd;
         op    = $urandom_range(0, 2);
         rd    = (op != 1);
         wr    = (op != 0);
         stall = $urandom_range(0, 10);
         rdv   = $urandom;
         a     = 16'($urandom);
         wd    = $urandom;
         to    = (stall >= T);
         exp_s = to ? T : stall + 1;
         if (!wr) m_rd = to ? DEAD : rdv;
         if (to) begin
            m_err = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         applyStimulus(rd, wr, a, wd, stall, rdv, 0, 1'($urandom_range(0, 1)),
                       s_cnt, l_cnt, r_val, ops_ok);
         checkOutput($sformatf("rnd%0d_strobes", n), 32'(s_cnt), 32'(exp_s));
         checkOutput($sformatf("rnd%0d_latency", n), 32'(l_cnt), 32'(exp_s + 1));
         checkOutput($sformatf("rnd%0d_readdata", n), r_val, m_rd);
         checkOutput($sformatf("rnd%0d_error", n), 32'(timeout_error), 32'(m_err));
         checkOutput($sformatf("rnd%0d_count", n), 32'(timeout_count), 32'(m_cnt));
         checkOutput($sformatf("rnd%0d_chan_request", n), 32'(ops_ok), 32'd1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
